// File: rtl/sram_stream_fifo_pkg.sv
// Shared types and helpers for sram_stream_fifo.
package sram_stream_fifo_pkg;

    // Output buffer depth behind the SRAM read port.
    localparam int unsigned OutbufDepth  = 2;
    // Widest payload an output-buffer entry can carry; narrower payloads use the low bits.
    localparam int unsigned MaxDataWidth = 128;

    typedef struct packed {
        logic                    valid;
        logic [MaxDataWidth-1:0] data;
    } buf_entry_t;

    // Index width for a range of n values (at least one bit).
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Total words the FIFO can hold: SRAM plus output buffer.
    function automatic int unsigned fifo_capacity(input int unsigned num_words);
        return num_words + OutbufDepth;
    endfunction

endpackage

// File: rtl/sram_stream_fifo_outbuf.sv
// Two-entry in-order output buffer; entry 0 is the head presented downstream.
module sram_stream_fifo_outbuf
    import sram_stream_fifo_pkg::*;
#(
    parameter int unsigned DataWidth = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic                 push_i,
    input  logic [DataWidth-1:0] push_data_i,
    input  logic                 pop_i,
    output logic [1:0]           count_o,
    output logic                 valid_o,
    output logic [DataWidth-1:0] data_o
);

    buf_entry_t entry_q [OutbufDepth];
    buf_entry_t entry_d [OutbufDepth];
    logic       unused_hi;

    // Pop shifts entry 1 into the head, then a push lands in the first free slot.
    always_comb begin
        entry_d[0] = entry_q[0];
        entry_d[1] = entry_q[1];
        if (pop_i) begin
            entry_d[0] = entry_q[1];
            entry_d[1] = '0;
        end
        if (push_i) begin
            if (!entry_d[0].valid) begin
                entry_d[0].valid = 1'b1;
                entry_d[0].data  = MaxDataWidth'(push_data_i);
            end else begin
                entry_d[1].valid = 1'b1;
                entry_d[1].data  = MaxDataWidth'(push_data_i);
            end
        end
        if (flush_i) begin
            entry_d[0] = '0;
            entry_d[1] = '0;
        end
    end

    // Entry registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            entry_q[0] <= '0;
            entry_q[1] <= '0;
        end else begin
            entry_q[0] <= entry_d[0];
            entry_q[1] <= entry_d[1];
        end
    end

    assign valid_o   = entry_q[0].valid;
    assign data_o    = entry_q[0].data[DataWidth-1:0];
    assign count_o   = 2'(entry_q[0].valid) + 2'(entry_q[1].valid);
    // Bits above DataWidth carry no payload.
    assign unused_hi = ^{entry_q[0].data, entry_q[1].data};

`ifndef SYNTHESIS
    // A pop always consumes a valid head; a push never lands in a full buffer.
    assert property (@(posedge clk_i) disable iff (rst_i) pop_i |-> entry_q[0].valid);
    assert property (@(posedge clk_i) disable iff (rst_i)
        push_i |-> !(entry_q[1].valid && !pop_i));
`endif

endmodule

// File: rtl/sram_stream_fifo.sv
// Stream FIFO on a single-port latency-1 SRAM plus a 2-entry output buffer.
// Optional write bypass into the output buffer: define SRAM_STREAM_FIFO_BYPASS_EN.
module sram_stream_fifo
    import sram_stream_fifo_pkg::*;
#(
    parameter int unsigned NumWords   = 1024,
    parameter int unsigned DataWidth  = 32,
    parameter int unsigned AddrWidth  = idx_width(NumWords),
    parameter int unsigned UsageWidth = idx_width(NumWords + 3)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DataWidth-1:0]  in_data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DataWidth-1:0]  out_data_o,
    output logic [UsageWidth-1:0] usage_o,
    output logic                  empty_o,
    output logic                  full_o
);

    localparam int unsigned Capacity = fifo_capacity(NumWords);

    logic [AddrWidth-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [UsageWidth-1:0] sram_cnt_q, sram_cnt_d, usage_q, usage_d;
    logic                  rd_inflight_q, rd_inflight_d;
    logic                  starve_q, starve_d;
    logic                  in_ready_q, in_ready_d;
    logic                  empty_q, empty_d, full_q, full_d;

    logic [DataWidth-1:0]  sram_mem [NumWords];
    logic [DataWidth-1:0]  sram_rdata_q;

    logic                  push_c, pop_c, rd_elig_c, rd_go_c, wr_go_c, bypass_c;
    logic                  buf_push_c;
    logic [DataWidth-1:0]  buf_push_data_c;
    logic [1:0]            buf_cnt;
    logic [2:0]            occ_c;

    // Handshakes and SRAM port arbitration (push wins; the guard cycle lets the read through).
    assign in_ready_o = in_ready_q & ~flush_i;
    assign push_c     = in_valid_i & in_ready_o;
    assign pop_c      = out_valid_o & out_ready_i;
    assign occ_c      = 3'(buf_cnt) + 3'(rd_inflight_q) - 3'(pop_c);
    assign rd_elig_c  = (sram_cnt_q != '0) && (occ_c < 3'd2) && !flush_i;
`ifdef SRAM_STREAM_FIFO_BYPASS_EN
    assign bypass_c   = push_c && (sram_cnt_q == '0) && !rd_inflight_q && (occ_c < 3'd2);
`else
    assign bypass_c   = 1'b0;
`endif
    assign wr_go_c    = push_c & ~bypass_c;
    assign rd_go_c    = rd_elig_c & ~wr_go_c;

    // Output buffer fill: captured read data, or a bypassed push.
    assign buf_push_c      = (rd_inflight_q & ~flush_i) | bypass_c;
    assign buf_push_data_c = rd_inflight_q ? sram_rdata_q : in_data_i;

    // Next-state for pointers, counters and status flags.
    always_comb begin
        wptr_d        = wptr_q;
        rptr_d        = rptr_q;
        sram_cnt_d    = sram_cnt_q + UsageWidth'(wr_go_c) - UsageWidth'(rd_go_c);
        usage_d       = usage_q + UsageWidth'(push_c) - UsageWidth'(pop_c);
        rd_inflight_d = rd_go_c;
        starve_d      = rd_elig_c & wr_go_c;
        if (wr_go_c) begin
            wptr_d = (wptr_q == AddrWidth'(NumWords - 1)) ? '0 : wptr_q + AddrWidth'(1);
        end
        if (rd_go_c) begin
            rptr_d = (rptr_q == AddrWidth'(NumWords - 1)) ? '0 : rptr_q + AddrWidth'(1);
        end
        if (flush_i) begin
            wptr_d        = '0;
            rptr_d        = '0;
            sram_cnt_d    = '0;
            usage_d       = '0;
            rd_inflight_d = 1'b0;
            starve_d      = 1'b0;
        end
        full_d     = (usage_d == UsageWidth'(Capacity));
        empty_d    = (usage_d == '0);
        in_ready_d = !full_d && !starve_d;
    end

    // Control state registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q        <= '0;
            rptr_q        <= '0;
            sram_cnt_q    <= '0;
            usage_q       <= '0;
            rd_inflight_q <= 1'b0;
            starve_q      <= 1'b0;
            in_ready_q    <= 1'b0;
            empty_q       <= 1'b1;
            full_q        <= 1'b0;
        end else begin
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
            sram_cnt_q    <= sram_cnt_d;
            usage_q       <= usage_d;
            rd_inflight_q <= rd_inflight_d;
            starve_q      <= starve_d;
            in_ready_q    <= in_ready_d;
            empty_q       <= empty_d;
            full_q        <= full_d;
        end
    end

    // Single-port SRAM: one write or one read per cycle, read data one cycle later.
    always_ff @(posedge clk_i) begin
        if (wr_go_c) begin
            sram_mem[wptr_q] <= in_data_i;
        end
        if (rd_go_c) begin
            sram_rdata_q <= sram_mem[rptr_q];
        end
    end

    sram_stream_fifo_outbuf #(
        .DataWidth (DataWidth)
    ) u_outbuf (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .push_i      (buf_push_c),
        .push_data_i (buf_push_data_c),
        .pop_i       (pop_c),
        .count_o     (buf_cnt),
        .valid_o     (out_valid_o),
        .data_o      (out_data_o)
    );

    assign usage_o = usage_q;
    assign empty_o = empty_q;
    assign full_o  = full_q;

`ifndef SYNTHESIS
    // Occupancy never exceeds the storage it describes.
    assert property (@(posedge clk_i) disable iff (rst_i) usage_q <= UsageWidth'(Capacity));
    assert property (@(posedge clk_i) disable iff (rst_i) sram_cnt_q <= UsageWidth'(NumWords));
    assert property (@(posedge clk_i) disable iff (rst_i) !(usage_q == '0 && pop_c));
`endif

endmodule
